// File: rtl/simon_says_pkg.sv
// Shared types and constants for the simon_says memory game.
//   state_t      : game FSM state encoding (3 bits)
//   MAX_LEN      : longest sequence / number of rounds to win
//   LFSR_SEED    : reset value of the colour generator
//   SEG_*        : active-low seven-segment patterns, bit order gfedcba
//   colour_led() : colour index -> one-hot LED pattern
//   seg_digit()  : 0..15 -> seven-segment pattern
package simon_says_pkg;

    typedef enum logic [2:0] {
        START          = 3'd0,
        GEN_RAND_NUM   = 3'd1,
        BLINK          = 3'd2,
        ACCEPT_INPUT   = 3'd3,
        VALIDATE_INPUT = 3'd4,
        WIN            = 3'd5,
        DEFAULT        = 3'd6
    } state_t;

    localparam int MAX_LEN = 10;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [3:0] colour_led(input logic [1:0] colour);
        return 4'b0001 << colour;
    endfunction

    function automatic logic [6:0] seg_digit(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'd10:   seg = SEG_A;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting towards the MSB.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, loads LFSR_SEED
//   en    : advance one step this cycle
//   lfsr  : current register value
module simon_lfsr
    import simon_says_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] lfsr
);

    logic feedback;
    assign feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (en) begin
            lfsr <= {lfsr[6:0], feedback};
        end
    end

endmodule

// File: rtl/simon_says.sv
// Simon-says memory game top level.
//   CLOCK_50 : system clock, rising edge
//   KEY[0]   : asynchronous active-low reset (KEY[3:1] unused)
//   SW[3:0]  : one-hot player colour entry (SW[9:4] unused)
//   LEDR[3:0]: one-hot playback of the sequence; LEDR = 10'h3FF on a win
//   LEDR[9:4]: zero outside WIN unless SIMON_DEBUG_EN is defined, in which case
//              LEDR[9:7] = state encoding and LEDR[5:4] = expected colour
//   HEX0     : active-low 7-seg of the current level ("A" on a win)
// Each round appends one LFSR colour to a shift-register sequence, plays it back
// oldest first (BLINK_CYCLES on, BLINK_CYCLES dark per entry), then checks the
// player's entries in the same order.
module simon_says
    import simon_says_pkg::*;
#(
    parameter int unsigned BLINK_CYCLES = 25_000_000
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0
);

    logic rst_n;
    assign rst_n = KEY[0];

    logic unused_inputs;
    assign unused_inputs = ^{KEY[3:1], SW[9:4]};

    logic [7:0] lfsr;

    simon_lfsr u_lfsr (
        .clk  (CLOCK_50),
        .rst_n(rst_n),
        .en   (1'b1),
        .lfsr (lfsr)
    );

    // Input synchroniser plus one extra stage for rising-edge (press) detection
    logic [3:0] sync1, sync2, sync_prev;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 4'd0;
            sync2     <= 4'd0;
            sync_prev <= 4'd0;
        end else begin
            sync1     <= SW[3:0];
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    logic       press;
    logic [1:0] press_colour;
    logic       press_valid;

    assign press = (sync2 != 4'd0) && (sync_prev == 4'd0);

    always_comb begin
        press_colour = 2'd0;
        press_valid  = 1'b1;
        case (sync2)
            4'b0001: press_colour = 2'd0;
            4'b0010: press_colour = 2'd1;
            4'b0100: press_colour = 2'd2;
            4'b1000: press_colour = 2'd3;
            default: press_valid  = 1'b0;
        endcase
    end

    state_t                     state;
    logic [MAX_LEN-1:0][1:0]    mem;      // entry 0 newest, entry level-1 oldest
    logic [3:0]                 level;
    logic [3:0]                 index;    // position in playback/check order
    logic [31:0]                timer;
    logic                       gap;      // 0: LED lit, 1: dark gap
    logic [3:0]                 led;
    logic [1:0]                 in_colour;
    logic                       in_bad;

    logic [1:0] expected;
    logic [1:0] first_colour;

    assign expected = (level == 4'd0) ? 2'd0 : mem[level - 4'd1 - index];
    // Oldest entry once the new colour has been shifted in
    assign first_colour = (level == 4'd0) ? lfsr[1:0] : mem[level - 4'd1];

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= START;
            mem       <= '0;
            level     <= 4'd0;
            index     <= 4'd0;
            timer     <= 32'd0;
            gap       <= 1'b0;
            led       <= 4'd0;
            in_colour <= 2'd0;
            in_bad    <= 1'b0;
        end else begin
            case (state)
                START: begin
                    mem   <= '0;
                    level <= 4'd0;
                    index <= 4'd0;
                    led   <= 4'd0;
                    state <= GEN_RAND_NUM;
                end
                GEN_RAND_NUM: begin
                    mem   <= {mem[MAX_LEN-2:0], lfsr[1:0]};
                    level <= level + 4'd1;
                    index <= 4'd0;
                    timer <= 32'd0;
                    gap   <= 1'b0;
                    led   <= colour_led(first_colour);
                    state <= BLINK;
                end
                BLINK: begin
                    if (timer == BLINK_CYCLES - 1) begin
                        timer <= 32'd0;
                        if (!gap) begin
                            gap <= 1'b1;
                            led <= 4'd0;
                        end else if (index == level - 4'd1) begin
                            index <= 4'd0;
                            state <= ACCEPT_INPUT;
                        end else begin
                            index <= index + 4'd1;
                            gap   <= 1'b0;
                            led   <= colour_led(mem[level - 4'd2 - index]);
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                ACCEPT_INPUT: begin
                    led <= 4'd0;
                    if (press) begin
                        in_colour <= press_colour;
                        in_bad    <= !press_valid;
                        state     <= VALIDATE_INPUT;
                    end
                end
                VALIDATE_INPUT: begin
                    if (in_bad || (in_colour != expected)) begin
                        state <= START;
                    end else if (index != level - 4'd1) begin
                        index <= index + 4'd1;
                        state <= ACCEPT_INPUT;
                    end else if (level == 4'(MAX_LEN)) begin
                        state <= WIN;
                    end else begin
                        state <= GEN_RAND_NUM;
                    end
                end
                WIN: begin
                    state <= WIN;
                end
                default: begin
                    state <= START;
                end
            endcase
        end
    end

    logic [5:0] dbg;

`ifdef SIMON_DEBUG_EN
    assign dbg = {state, 1'b0, expected};
`else
    assign dbg = 6'd0;
`endif

    assign LEDR = (state == WIN) ? 10'h3FF : {dbg, led};
    assign HEX0 = (state == WIN) ? SEG_A : seg_digit(level);

endmodule

// File: tb/tb_simon_says.sv
// Bench for simon_says with BLINK_CYCLES = 1. A game-level model turns each
// round into a queue of expected per-cycle outputs; one process compares the
// DUT against it every cycle, and the stimulus adds hand-computed spot checks.
module tb_simon_says;

    localparam int unsigned B = 1;

    logic       clk = 1'b0;
    logic [3:0] key;
    logic [9:0] sw;
    logic [9:0] ledr;
    logic [6:0] hex0;

    always #5 clk = ~clk;

    simon_says #(.BLINK_CYCLES(B)) dut (
        .CLOCK_50(clk),
        .KEY     (key),
        .SW      (sw),
        .LEDR    (ledr),
        .HEX0    (hex0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- game model ----------------
    typedef struct {
        logic [9:0] led;
        logic [6:0] hex;
        bit         hex_care;
    } exp_t;

    logic [6:0] seg_tab [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h08};

    exp_t       exp_q[$];
    int         seq[$];      // colours, oldest first
    int         level_m = 0;
    int         pos = 0;
    bit         won = 1'b0;
    bit         in_reset = 1'b1;
    logic [7:0] lfsr_m = 8'hA5;
    logic [3:0] h1 = 4'd0, h2 = 4'd0, h3 = 4'd0;

    // Polynomial x^8+x^6+x^5+x^4+1: new bit is parity of the tapped positions
    function automatic logic [7:0] lfsr_adv(input logic [7:0] v, input int steps);
        logic [7:0] r;
        r = v;
        for (int s = 0; s < steps; s++) r = {r[6:0], ^(r & 8'b1011_1000)};
        return r;
    endfunction

    function automatic void push(input logic [9:0] led, input int hexlvl);
        exp_t e;
        e.led      = led;
        e.hex      = (hexlvl < 0) ? 7'h7F : seg_tab[hexlvl];
        e.hex_care = (hexlvl >= 0);
        exp_q.push_back(e);
    endfunction

    // gen_off: cycles from now until the colour-generation cycle
    function automatic void start_round(input int gen_off);
        logic [7:0] v;
        v = lfsr_adv(lfsr_m, gen_off);
        seq.push_back(int'(v[1:0]));
        level_m = seq.size();
        pos     = 0;
        push(10'd0, -1);
        foreach (seq[i]) begin
            for (int k = 0; k < int'(B); k++) push(10'(1 << seq[i]), level_m);
            for (int k = 0; k < int'(B); k++) push(10'd0, level_m);
        end
    endfunction

    // Inputs as seen at each rising edge (value held during the previous cycle)
    always @(posedge clk) begin
        h3 <= h2;
        h2 <= h1;
        h1 <= sw[3:0];
    end

    initial begin
        exp_t e;
        int   c;
        forever begin
            @(negedge clk);
            if (key[0] !== 1'b1) begin
                check("reset_ledr", ledr, 10'd0);
                check("reset_hex0", {3'b0, hex0}, 10'h040);
                exp_q.delete();
                seq.delete();
                level_m  = 0;
                pos      = 0;
                won      = 1'b0;
                in_reset = 1'b1;
                lfsr_m   = 8'hA5;
            end else begin
                if (in_reset) begin
                    in_reset = 1'b0;
                    push(10'd0, -1);           // first cycle after reset release
                    start_round(1);
                end else if (exp_q.size() == 0 && !won && h2 != 4'd0 && h3 == 4'd0) begin
                    c = -1;
                    if ($countones(h2) == 1)
                        for (int b = 0; b < 4; b++) if (h2[b]) c = b;
                    push(10'd0, level_m);      // cycle the press is seen
                    push(10'd0, level_m);      // verdict cycle
                    if (c != seq[pos]) begin
                        push(10'd0, -1);       // restart cycle
                        seq.delete();
                        start_round(3);
                    end else if (pos == level_m - 1) begin
                        if (level_m == 10) won = 1'b1;
                        else start_round(2);
                    end else begin
                        pos++;
                    end
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                end else begin
                    e.led      = won ? 10'h3FF : 10'd0;
                    e.hex      = won ? seg_tab[10] : seg_tab[level_m];
                    e.hex_care = 1'b1;
                end
                check("ledr", ledr, e.led);
                if (e.hex_care) check("hex0", {3'b0, hex0}, {3'b0, e.hex});
                lfsr_m = lfsr_adv(lfsr_m, 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        sw = {6'd0, mask};
        step(hold);
        sw = 10'd0;
        step(4);
    endtask

    task automatic wait_idle(input string what);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            step(1);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: still playing after %0d cycles, required idle", what, k);
        end
    endtask

    // Enter the current sequence; entry number 'wrong_at' gets a different colour
    task automatic play_seq(input int wrong_at);
        int cols[$];
        int m;
        cols = seq;
        foreach (cols[i]) begin
            m = cols[i];
            if (i == wrong_at) m = (m + 1) % 4;
            wait_idle("accept_wait");
            press(4'(1 << m), (i == 0) ? 5 : 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        key = 4'b1110;
        sw  = 10'd0;
        step(4);
        key[0] = 1'b1;
        // Seed A5 steps to 4A, so the first colour is 2
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("first_blink_ledr", ledr, 10'h004);
        check("first_blink_hex0", {3'b0, hex0}, 10'h079);
        step(1);

        wait_idle("round1");
        check("round1_wait_ledr", ledr, 10'd0);
        press(4'b0100, 2);
        wait_idle("round2");
        check("level2_hex0", {3'b0, hex0}, 10'h024);

        play_seq(-1);                  // first entry held for several cycles
        sw = 10'd1;                    // pulse while level 3 is playing back
        step(1);
        sw = 10'd0;
        wait_idle("round3");
        check("level3_hex0", {3'b0, hex0}, 10'h030);

        play_seq(2);
        wait_idle("restart_wrong");
        check("wrong_restart_hex0", {3'b0, hex0}, 10'h079);

        press(4'b0101, 1);
        wait_idle("restart_invalid");
        check("invalid_restart_hex0", {3'b0, hex0}, 10'h079);
        check("invalid_restart_ledr", ledr, 10'd0);

        play_seq(-1);                  // returns during level-2 playback
        key[0] = 1'b0;
        #1;
        check("midblink_reset_ledr", ledr, 10'd0);
        check("midblink_reset_hex0", {3'b0, hex0}, 10'h040);
        step(3);
        key[0] = 1'b1;
        step(1);

        for (int r = 0; r < 10; r++) begin
            wait_idle("win_round");
            play_seq(-1);
        end
        wait_idle("win");
        check("win_ledr", ledr, 10'h3FF);
        check("win_hex0", {3'b0, hex0}, 10'h008);
        press(4'b0001, 1);
        step(10);
        check("win_hold_ledr", ledr, 10'h3FF);
        check("win_hold_hex0", {3'b0, hex0}, 10'h008);

        key[0] = 1'b0;
        #1;
        check("win_reset_ledr", ledr, 10'd0);
        check("win_reset_hex0", {3'b0, hex0}, 10'h040);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
